vga_output: RTL and testbench
=============================

# vga_output

Display-side consumer of the rasterizer pixel stream. Buffers 1-bit-per-channel pixels in a small FIFO with ready/valid backpressure and generates VGA timing (800x600@60 default). Emits registered RGB and sync to the DAC/pins, and aligns to frames using a start-of-frame marker. It sits between the render pipeline and the board VGA connector.

## Interface
- H_VISIBLE, 800, active pixels per line
- H_FRONT / H_SYNC / H_BACK, 40 / 128 / 88, horizontal porch and sync widths in clocks
- V_VISIBLE, 600, active lines
- V_FRONT / V_SYNC / V_BACK, 1 / 4 / 23, vertical porch and sync widths in lines
- SYNC_POL, 1, active level of hsync and vsync
- FIFO_DEPTH, 16, pixel FIFO entries; must be a power of two and at least 2
- clk  in  1  pixel clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_vld  in  1  pixel valid
- in_rdy  out  1  FIFO can accept a pixel; equals !full
- in_sof  in  1  marks first pixel (0,0) of a frame
- in_red / in_green / in_blue  in  1 each  pixel colour
- vga_hsync / vga_vsync  out  1 each  sync outputs
- vga_red / vga_green / vga_blue  out  1 each  colour outputs; 0 outside the visible area
- err_underflow  out  1  sticky flag, set when a visible pixel was needed and the FIFO was empty
- err_align  out  1  sticky flag, set when an in_sof pixel reaches the FIFO head outside (0,0)

## Operation
- FIFO entry: {sof, r, g, b}. Write on in_vld && in_rdy. Pop rules are given below. The occupancy counter is clog2(FIFO_DEPTH)+1 bits wide. A simultaneous push and pop leaves occupancy unchanged.
- Counters: h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK. v_cnt increments when h_cnt wraps, and v_cnt wraps at V_TOTAL-1. Both are free-running from reset.
- visible = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE.
- hsync is active for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC. vsync uses the analogous v_cnt window.
- State machine with two states, WAIT_SOF (reset state) and RUN.
- WAIT_SOF:
  - If the head entry has sof=0, pop it (discard). This is one pop per cycle while non-empty.
  - If the head has sof=1, hold it until h_cnt==0 && v_cnt==0. In that cycle, pop it, display it, and go to RUN.
  - Colour output is black; sync continues normally.
- RUN:
  - Each visible cycle pops the head and displays it.
  - Visible cycle with an empty FIFO: output black, set err_underflow, go to WAIT_SOF.
  - Head has sof=1 at any position other than (0,0): set err_align, output black, do not pop, go to WAIT_SOF. That entry then starts the next frame.
  - Non-visible cycles never pop.
- Sticky flags clear only on reset.
- Reset mid-operation: FIFO is flushed, counters return to (0,0), and the state returns to WAIT_SOF.

## Timing
- Reset values:
  - vga_red/green/blue = 0
  - vga_hsync = vga_vsync = !SYNC_POL
  - err_underflow = err_align = 0
  - h_cnt = v_cnt = 0
  - FIFO empty, so in_rdy = 1 once rst_n is high
- All VGA outputs are registered. The value for counter position (h,v) appears one cycle after the counters hold (h,v). Sync and colour share that same stage, so they stay aligned.
- Minimum input-to-pin latency is 2 cycles: write cycle, then the pop/display cycle, then the output register.
- in_rdy is combinational from occupancy only. It never depends on in_vld.
- A pop frees the entry for a write in the next cycle; in_rdy rises in the cycle after the pop.

## Configuration
- VGA_OUTPUT_TESTPATTERN_EN defined: visible cycles while in WAIT_SOF, or on an underflow/align event, drive colour bars instead of black, with {r,g,b} = h_cnt[6:4].
- Not defined: those cycles output black. Sync and flag behaviour are identical in both builds.

## Structure
- Shared package vga_pkg:
  - typedef pixel_t for {sof, r, g, b}
  - enum state_t {WAIT_SOF, RUN}
  - default 800x600 timing constants, reused by render for WIDTH/HEIGHT
- One sub-module, pixel_fifo: parameterised synchronous FIFO with first-word-fall-through head, async active-low reset, and full/empty outputs.

## Test plan
Run with small timing: H_VISIBLE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=3, V_FRONT=V_SYNC=V_BACK=1, FIFO_DEPTH=4.
- Reset: hold rst_n=0 for 3 clocks -> all colour 0, hsync=vsync=0, flags 0, in_rdy=1 after release.
- Full frame streamed: 12 pixels with sof on the first, colour = index[2:0], always valid -> outputs show 12 colours in raster order, each 1 cycle after its counter position; hsync high for h_cnt 5..6, delayed by 1; no flags set.
- Backpressure: no pops, write 5 pixels -> in_rdy drops after the 4th write; the 5th is accepted only after the first pop.
- Underflow: stop input after 6 pixels -> pixel 7 position outputs black, err_underflow=1, state WAIT_SOF; next sof pixel is displayed at the next (0,0).
- Misalignment: sof on the 3rd pixel -> that position outputs black, err_align=1; the sof pixel is displayed at the next (0,0).
- Garbage before sof: 3 pixels with sof=0, then a frame -> first 3 discarded, frame displayed intact, no flags set.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types and default 800x600@60 timing constants (also used by render for WIDTH/HEIGHT).
package vga_pkg;

    localparam int unsigned VGA_H_VISIBLE  = 800;
    localparam int unsigned VGA_H_FRONT    = 40;
    localparam int unsigned VGA_H_SYNC     = 128;
    localparam int unsigned VGA_H_BACK     = 88;
    localparam int unsigned VGA_V_VISIBLE  = 600;
    localparam int unsigned VGA_V_FRONT    = 1;
    localparam int unsigned VGA_V_SYNC     = 4;
    localparam int unsigned VGA_V_BACK     = 23;
    localparam bit          VGA_SYNC_POL   = 1'b1;
    localparam int unsigned VGA_FIFO_DEPTH = 16;

    // One buffered pixel: frame marker plus 1-bit colour channels
    typedef struct packed {
        logic sof;
        logic r;
        logic g;
        logic b;
    } pixel_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with first-word-fall-through head and registered full/empty flags.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  pixel_t din,
    input  logic   pop,
    output pixel_t head_c,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = cnt_width(DEPTH);
    localparam int unsigned CW = AW + 1;

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop cancel out
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/vga_output.sv
// VGA scan-out: buffers the render pixel stream, generates timing and aligns frames on the sof marker.
// Optional build macro VGA_OUTPUT_TESTPATTERN_EN: colour bars instead of black while unsynchronised.
module vga_output
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT    = VGA_H_FRONT,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BACK     = VGA_H_BACK,
    parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT    = VGA_V_FRONT,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BACK     = VGA_V_BACK,
    parameter bit          SYNC_POL   = VGA_SYNC_POL,
    parameter int unsigned FIFO_DEPTH = VGA_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic in_rdy,
    input  logic in_sof,
    input  logic in_red,
    input  logic in_green,
    input  logic in_blue,
    output logic vga_hsync,
    output logic vga_vsync,
    output logic vga_red,
    output logic vga_green,
    output logic vga_blue,
    output logic err_underflow,
    output logic err_align
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    state_t        state;
    state_t        state_nxt;
    pixel_t        head_c;
    pixel_t        din_c;
    logic          fifo_full;
    logic          fifo_empty;
    logic          visible_c;
    logic          origin_c;
    logic          hs_win_c;
    logic          vs_win_c;
    logic          pop_c;
    logic          show_c;
    logic          uf_c;
    logic          al_c;
    logic [2:0]    rgb_c;

    assign din_c  = '{sof: in_sof, r: in_red, g: in_green, b: in_blue};
    assign in_rdy = !fifo_full;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_vld),
        .din    (din_c),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Free-running raster position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign visible_c = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
    assign origin_c  = (h_cnt == '0) && (v_cnt == '0);
    assign hs_win_c  = (h_cnt >= HW'(H_VISIBLE + H_FRONT)) &&
                       (h_cnt <  HW'(H_VISIBLE + H_FRONT + H_SYNC));
    assign vs_win_c  = (v_cnt >= VW'(V_VISIBLE + V_FRONT)) &&
                       (v_cnt <  VW'(V_VISIBLE + V_FRONT + V_SYNC));

    // Frame-alignment state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop/display decision and error detection for the current raster position
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        show_c    = 1'b0;
        uf_c      = 1'b0;
        al_c      = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (!fifo_empty) begin
                    if (!head_c.sof) begin
                        pop_c = 1'b1;
                    end else if (origin_c) begin
                        pop_c     = 1'b1;
                        show_c    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (visible_c) begin
                    if (fifo_empty) begin
                        uf_c      = 1'b1;
                        state_nxt = WAIT_SOF;
                    end else if (head_c.sof && !origin_c) begin
                        // Leave the early sof entry in place so it starts the next frame
                        al_c      = 1'b1;
                        state_nxt = WAIT_SOF;
                    end else begin
                        pop_c  = 1'b1;
                        show_c = 1'b1;
                    end
                end
            end
        endcase
    end

    // Colour for the current position: displayed pixel, optional bars, or black
    always_comb begin
        rgb_c = 3'b000;
        if (show_c) begin
            rgb_c = {head_c.r, head_c.g, head_c.b};
        end
`ifdef VGA_OUTPUT_TESTPATTERN_EN
        else if (visible_c && (state == WAIT_SOF || uf_c || al_c)) begin
            rgb_c = 3'(32'(h_cnt) >> 4);
        end
`endif
    end

    // Output stage: sync and colour registered together so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync     <= !SYNC_POL;
            vga_vsync     <= !SYNC_POL;
            vga_red       <= 1'b0;
            vga_green     <= 1'b0;
            vga_blue      <= 1'b0;
            err_underflow <= 1'b0;
            err_align     <= 1'b0;
        end else begin
            vga_hsync <= hs_win_c ? SYNC_POL : !SYNC_POL;
            vga_vsync <= vs_win_c ? SYNC_POL : !SYNC_POL;
            {vga_red, vga_green, vga_blue} <= rgb_c;
            if (uf_c) begin
                err_underflow <= 1'b1;
            end
            if (al_c) begin
                err_align <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_output.sv
// Bench for vga_output with a reduced 8x6 raster and a 4-entry FIFO; queue-based reference model.
module tb_vga_output;
    import vga_pkg::*;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int DEPTH = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit POL = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_vld = 1'b0;
    logic in_rdy;
    logic in_sof = 1'b0;
    logic in_red = 1'b0;
    logic in_green = 1'b0;
    logic in_blue = 1'b0;
    logic vga_hsync, vga_vsync, vga_red, vga_green, vga_blue;
    logic err_underflow, err_align;

    always #5 clk = ~clk;

    vga_output #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL  (POL), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_sof        (in_sof),
        .in_red        (in_red),
        .in_green      (in_green),
        .in_blue       (in_blue),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_red       (vga_red),
        .vga_green     (vga_green),
        .vga_blue      (vga_blue),
        .err_underflow (err_underflow),
        .err_align     (err_align)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: cycle index since reset, buffered pixels, pending source pixels
    int          t;
    pixel_t      mq[$];
    pixel_t      src[$];
    bit          m_synced;
    bit          m_uf;
    bit          m_al;
    int unsigned gap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic add_px(input bit sof, input logic [2:0] col);
        pixel_t p;
        p = '{sof: sof, r: col[2], g: col[1], b: col[0]};
        src.push_back(p);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rgb",   32'({vga_red, vga_green, vga_blue}), 32'd0);
        check_eq("rst_hsync", 32'(vga_hsync), 32'(!POL));
        check_eq("rst_vsync", 32'(vga_vsync), 32'(!POL));
        check_eq("rst_uf",    32'(err_underflow), 32'd0);
        check_eq("rst_al",    32'(err_align), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_rdy", 32'(in_rdy), 32'd1);
        mq.delete();
        src.delete();
        t        = 0;
        m_synced = 1'b0;
        m_uf     = 1'b0;
        m_al     = 1'b0;
    endtask

    // One pixel clock: drive source, predict from the raster rules, compare after the edge
    task automatic step();
        int         h, v;
        bit         vis, org, pop, show, push, event_hit;
        logic [2:0] col;
        pixel_t     p;
        h = t % HT;
        v = (t / HT) % VT;
        p = (src.size() > 0) ? src[0] : '0;
        in_vld = (src.size() > 0) && ($urandom_range(99) >= gap);
        {in_sof, in_red, in_green, in_blue} = p;
        #1;
        check_eq("in_rdy", 32'(in_rdy), 32'(mq.size() < DEPTH));

        vis = (h < HV) && (v < VV);
        org = (h == 0) && (v == 0);
        pop = 1'b0; show = 1'b0; event_hit = 1'b0;
        if (!m_synced) begin
            if (mq.size() > 0 && !mq[0].sof) pop = 1'b1;
            else if (mq.size() > 0 && org) begin
                pop = 1'b1; show = 1'b1; m_synced = 1'b1;
            end
        end else if (vis) begin
            if (mq.size() == 0) begin
                m_uf = 1'b1; m_synced = 1'b0; event_hit = 1'b1;
            end else if (mq[0].sof && !org) begin
                m_al = 1'b1; m_synced = 1'b0; event_hit = 1'b1;
            end else begin
                pop = 1'b1; show = 1'b1;
            end
        end
        col = 3'b000;
        if (show) col = {mq[0].r, mq[0].g, mq[0].b};
`ifdef VGA_OUTPUT_TESTPATTERN_EN
        else if (vis && (!m_synced || event_hit)) col = 3'(h >> 4);
`endif
        push = in_vld && (mq.size() < DEPTH);

        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(p);
            void'(src.pop_front());
        end
        t++;
        #1;
        check_eq("rgb",   32'({vga_red, vga_green, vga_blue}), 32'(col));
        check_eq("hsync", 32'(vga_hsync), 32'((h >= HV + HF && h < HV + HF + HS) ? POL : !POL));
        check_eq("vsync", 32'(vga_vsync), 32'((v >= VV + VF && v < VV + VF + VS) ? POL : !POL));
        check_eq("err_underflow", 32'(err_underflow), 32'(m_uf));
        check_eq("err_align",     32'(err_align), 32'(m_al));
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    initial begin
        gap = 0;
        t   = 0;

        // Clean stream: index-coloured frame then two random frames, FIFO fills while waiting for sof
        do_reset();
        for (int i = 0; i < 12; i++) add_px(i == 0, 3'(i));
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 12; i++) add_px(i == 0, 3'($urandom_range(7)));
        run_to(4);
        #1;
        check_eq("bp_full_rdy", 32'(in_rdy), 32'd0);
        run_to(4 * FT);
        check_eq("clean_uf", 32'(err_underflow), 32'd0);
        check_eq("clean_al", 32'(err_align), 32'd0);

        // Underflow: six pixels then silence, then a fresh frame
        do_reset();
        for (int i = 0; i < 6; i++) add_px(i == 0, 3'($urandom_range(1, 7)));
        run_to(FT + 2 * HT);
        check_eq("uf_set", 32'(err_underflow), 32'd1);
        for (int i = 0; i < 12; i++) add_px(i == 0, 3'($urandom_range(7)));
        run_to(3 * FT);
        check_eq("uf_sticky", 32'(err_underflow), 32'd1);
        check_eq("uf_no_al",  32'(err_align), 32'd0);

        // Misalignment: sof on the third pixel restarts the frame
        do_reset();
        for (int i = 0; i < 14; i++) add_px(i == 0 || i == 2, 3'($urandom_range(1, 7)));
        run_to(3 * FT);
        check_eq("al_set",   32'(err_align), 32'd1);
        check_eq("al_no_uf", 32'(err_underflow), 32'd0);

        // Garbage ahead of the first sof is discarded silently
        do_reset();
        for (int i = 0; i < 3; i++) add_px(1'b0, 3'($urandom_range(7)));
        for (int i = 0; i < 12; i++) add_px(i == 0, 3'($urandom_range(7)));
        run_to(2 * FT);
        check_eq("garb_uf", 32'(err_underflow), 32'd0);
        check_eq("garb_al", 32'(err_align), 32'd0);

        // Random traffic: gaps, stray sof markers, resets landing mid-stream
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) do_reset();
            gap = $urandom_range(30);
            for (int f = 0; f < 2; f++)
                for (int i = 0; i < 12; i++)
                    add_px(i == 0 || ($urandom_range(15) == 0), 3'($urandom_range(7)));
            run_to(t + 2 * FT);
        end
        gap = 0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
